// File: rtl/quad_encoder_decoder.sv
// quad_encoder_decoder
//   Front end for the rotary encoder. Each raw contact (A, B) is passed
//   through a 2-FF synchroniser and a stability-count debouncer. A
//   quadrature FSM runs on the debounced pair {A,B} and emits one-cycle
//   step strobes when a full detent-to-detent cycle completes.
//
//   Ports:
//     clk_i        system clock
//     rst_n_i      asynchronous active-low reset
//     a_i, b_i     raw encoder contacts (asynchronous, idle high)
//     a_db_o       debounced A level
//     b_db_o       debounced B level
//     step_up_o    one-cycle strobe per completed clockwise detent
//     step_down_o  one-cycle strobe per completed counter-clockwise detent
//     err_cnt_o    (ENC_ERR_CNT_EN only) saturating count of illegal
//                  both-bits-change events and entries into WAIT_IDLE
//
//   Optional feature macro: ENC_ERR_CNT_EN
module quad_encoder_decoder #(
    parameter int unsigned CLOCK_FREQ_MHZ = 100,
    parameter int unsigned DELAY_IN_US    = 55,
    parameter int unsigned DELAY_TICKS    = CLOCK_FREQ_MHZ * DELAY_IN_US,
    parameter int unsigned CNT_W          = $clog2(DELAY_TICKS + 1)
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       a_i,
    input  logic       b_i,
    output logic       a_db_o,
    output logic       b_db_o,
    output logic       step_up_o,
    output logic       step_down_o
`ifdef ENC_ERR_CNT_EN
   ,output logic [7:0] err_cnt_o
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        R1,
        R2,
        R3,
        L1,
        L2,
        L3,
        WAIT_IDLE
    } state_e;

    // Channel vectors: bit 1 = A, bit 0 = B, so db_q reads as the {A,B} pair.
    logic [1:0]       sync1_q;
    logic [1:0]       sync2_q;
    logic [1:0]       db_q;
    logic [1:0]       db_d;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];

    state_e           state_q;
    state_e           state_d;
    logic [1:0]       exp_pair;
    logic             illegal;
    logic             step_up_d;
    logic             step_up_q;
    logic             step_down_d;
    logic             step_down_q;

    // ------------------------------------------------------------------
    // Synchroniser + debounce
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q <= '1;
            sync2_q <= '1;
            db_q    <= '1;
            for (int unsigned i = 0; i < 2; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= {a_i, b_i};
            sync2_q <= sync1_q;
            db_q    <= db_d;
            for (int unsigned i = 0; i < 2; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // The counter only runs while the synced level disagrees with the
    // debounced one; any agreeing sample restarts it, and reaching the
    // last count commits the new level, so the counter never wraps.
    always_comb begin
        db_d = db_q;
        for (int unsigned i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Quadrature FSM
    // ------------------------------------------------------------------
    // Every state except WAIT_IDLE implies the pair it was entered on, so a
    // both-bits change is detected against that implied pair.
    always_comb begin
        case (state_q)
            R1, L3:  exp_pair = 2'b01;
            R2, L2:  exp_pair = 2'b00;
            R3, L1:  exp_pair = 2'b10;
            default: exp_pair = 2'b11;
        endcase
    end

    assign illegal = (state_q != WAIT_IDLE) && ((db_q ^ exp_pair) == 2'b11);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (illegal) begin
            state_d = (db_q == 2'b11) ? IDLE : WAIT_IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (db_q == 2'b01)      state_d = R1;
                    else if (db_q == 2'b10) state_d = L1;
                end
                R1: begin
                    if (db_q == 2'b00)      state_d = R2;
                    else if (db_q == 2'b11) state_d = IDLE;
                end
                R2: begin
                    if (db_q == 2'b10)      state_d = R3;
                    else if (db_q == 2'b01) state_d = R1;
                end
                R3: begin
                    if (db_q == 2'b11)      state_d = IDLE;
                    else if (db_q == 2'b00) state_d = R2;
                end
                L1: begin
                    if (db_q == 2'b00)      state_d = L2;
                    else if (db_q == 2'b11) state_d = IDLE;
                end
                L2: begin
                    if (db_q == 2'b01)      state_d = L3;
                    else if (db_q == 2'b10) state_d = L1;
                end
                L3: begin
                    if (db_q == 2'b11)      state_d = IDLE;
                    else if (db_q == 2'b00) state_d = L2;
                end
                WAIT_IDLE: begin
                    if (db_q == 2'b11)      state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Strobes are decided from the current state and pair, then registered,
    // so they appear in the cycle after the debounced pair returns to 11.
    always_comb begin
        step_up_d   = (state_q == R3) && (db_q == 2'b11);
        step_down_d = (state_q == L3) && (db_q == 2'b11);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            step_up_q   <= 1'b0;
            step_down_q <= 1'b0;
        end else begin
            step_up_q   <= step_up_d;
            step_down_q <= step_down_d;
        end
    end

`ifdef ENC_ERR_CNT_EN
    logic [7:0] err_cnt_q;
    logic [7:0] err_cnt_d;
    logic       err_evt;

    // An illegal change that also lands in WAIT_IDLE is a single event.
    assign err_evt = illegal || ((state_d == WAIT_IDLE) && (state_q != WAIT_IDLE));

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_evt && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt_o = err_cnt_q;
`endif

    assign a_db_o      = db_q[1];
    assign b_db_o      = db_q[0];
    assign step_up_o   = step_up_q;
    assign step_down_o = step_down_q;

endmodule

// File: tb/tb_quad_encoder_decoder.sv
// tb_quad_encoder_decoder
//   Self-checking bench for quad_encoder_decoder. Uses a short debounce
//   (1 MHz x 8 us = 8 ticks). Expected strobes (direction + cycle) are queued
//   when the final contact edge of a detent is driven and matched against
//   strobes as they appear. Honours ENC_ERR_CNT_EN for err_cnt_o.
module tb_quad_encoder_decoder;

    localparam int unsigned FREQ = 1;
    localparam int unsigned DLY  = 8;
    localparam int unsigned DT   = FREQ * DLY;
    localparam int unsigned LAT  = DT + 3;

    logic clk = 1'b0;
    logic rst_n;
    logic a;
    logic b;
    logic a_db_o;
    logic b_db_o;
    logic step_up_o;
    logic step_down_o;
`ifdef ENC_ERR_CNT_EN
    logic [7:0] err_cnt_o;
`endif

    quad_encoder_decoder #(
        .CLOCK_FREQ_MHZ (FREQ),
        .DELAY_IN_US    (DLY)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .a_i         (a),
        .b_i         (b),
        .a_db_o      (a_db_o),
        .b_db_o      (b_db_o),
        .step_up_o   (step_up_o),
        .step_down_o (step_down_o)
`ifdef ENC_ERR_CNT_EN
       ,.err_cnt_o   (err_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [1:0]  dir;   // {up, down}
        int unsigned at;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned a_tog    = 0;
    logic        a_db_prev = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: count A db toggles, match every strobe against the scoreboard.
    always @(negedge clk) begin
        if (a_db_o !== a_db_prev) a_tog++;
        a_db_prev = a_db_o;
        if (step_up_o || step_down_o) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_strobe", {30'd0, step_up_o, step_down_o}, 32'd0);
            end else begin
                e = sb.pop_front();
                check_eq("strobe_dir", {30'd0, step_up_o, step_down_o}, {30'd0, e.dir});
                check_eq("strobe_cycle", cyc, e.at);
            end
        end
    end

    task automatic hold(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input logic [1:0] dir);
        exp_t x;
        x.dir = dir;
        x.at  = cyc + LAT;
        sb.push_back(x);
    endtask

    // Random chatter on A shorter than the debounce window, then settle on v.
    // The forced ~v sample caps any differing run below DT samples.
    task automatic bounce_a(input logic v);
        for (int i = 0; i < int'(DT) - 2; i++) begin
            a = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        a = ~v;
        @(negedge clk);
        a = v;
    endtask

    task automatic set_ch(input bit is_a, input logic v, input bit bnc);
        if (is_a) begin
            if (bnc) bounce_a(v);
            else     a = v;
        end else begin
            b = v;
        end
    endtask

    // right=1: A leads (11->01->00->10->11); right=0: B leads.
    task automatic detent(input bit right, input bit bnc);
        set_ch(right, 1'b0, bnc);  hold(3 * DT);
        set_ch(!right, 1'b0, bnc); hold(2 * DT);
        set_ch(right, 1'b1, bnc);  hold(3 * DT);
        set_ch(!right, 1'b1, bnc);
        push_exp(right ? 2'b10 : 2'b01);
        hold(3 * DT);
        check_eq("sb_drain", sb.size(), 32'd0);
    endtask

    int unsigned tog0;

    initial begin
        rst_n = 1'b0;
        a     = 1'b1;
        b     = 1'b1;
        hold(5);
        check_eq("rst_a_db", {31'd0, a_db_o}, 32'd1);
        check_eq("rst_b_db", {31'd0, b_db_o}, 32'd1);
        check_eq("rst_up", {31'd0, step_up_o}, 32'd0);
        check_eq("rst_down", {31'd0, step_down_o}, 32'd0);
`ifdef ENC_ERR_CNT_EN
        check_eq("rst_err", {24'd0, err_cnt_o}, 32'd0);
`endif
        rst_n = 1'b1;
        hold(2000);
        check_eq("idle_a_db", {31'd0, a_db_o}, 32'd1);
        check_eq("idle_b_db", {31'd0, b_db_o}, 32'd1);

        // Clean detents
        detent(1'b1, 1'b0);
        detent(1'b0, 1'b0);

        // Bouncing A contact: one db change per settled level
        tog0 = a_tog;
        detent(1'b1, 1'b1);
        check_eq("bounce_r_a_tog", a_tog - tog0, 32'd2);
        tog0 = a_tog;
        detent(1'b0, 1'b1);
        check_eq("bounce_l_a_tog", a_tog - tog0, 32'd2);

        // Reversal 11->01->00->01->11 and abort 11->01->11: no strobes
        a = 1'b0; hold(3 * DT);
        b = 1'b0; hold(3 * DT);
        b = 1'b1; hold(3 * DT);
        a = 1'b1; hold(3 * DT);
        a = 1'b0; hold(3 * DT);
        a = 1'b1; hold(3 * DT);
        check_eq("abort_a_db", {31'd0, a_db_o}, 32'd1);
        check_eq("abort_b_db", {31'd0, b_db_o}, 32'd1);
        detent(1'b1, 1'b0);

        // Reset mid-rotation: db returns to 11, then re-debounces to A low
        a = 1'b0; hold(3 * DT);
        rst_n = 1'b0; hold(2);
        check_eq("midrst_a_db", {31'd0, a_db_o}, 32'd1);
        rst_n = 1'b1; hold(3 * DT);
        check_eq("redb_a_db", {31'd0, a_db_o}, 32'd0);
        check_eq("redb_b_db", {31'd0, b_db_o}, 32'd1);
        a = 1'b1; hold(3 * DT);
        check_eq("midrst_a_back", {31'd0, a_db_o}, 32'd1);
        detent(1'b0, 1'b0);

        // Illegal: both drop together, then both rise
        a = 1'b0; b = 1'b0; hold(3 * DT);
        check_eq("ill_a_db", {31'd0, a_db_o}, 32'd0);
        check_eq("ill_b_db", {31'd0, b_db_o}, 32'd0);
        a = 1'b1; b = 1'b1; hold(3 * DT);
`ifdef ENC_ERR_CNT_EN
        check_eq("err_cnt", {24'd0, err_cnt_o}, 32'd1);
`endif
        detent(1'b1, 1'b0);

        hold(3 * DT);
        check_eq("sb_final", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
